// File: rtl/task_scheduler_pkg.sv
// Shared types and constants for the hardware test-run scheduler.
package task_scheduler_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StRstTm,
    StStart,
    StWaitDone,
    StFinish
  } sched_state_e;

  // Wide enough to hold candidate index NUMBER_OF_TASKS+1 for up to 32 tasks.
  localparam int unsigned TASK_IDX_W = $clog2(33);

  localparam int unsigned DEFAULT_RST_CYCLES     = 4;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1_000_000;

endpackage

// File: rtl/task_scheduler_if.sv
// Control/status and task_manager-facing signals of the scheduler.
interface task_scheduler_if #(
  parameter int unsigned CNT_W = 32
);
  logic             i_run;
  logic             i_abort;
  logic [31:0]      i_enabled_tasks;
  logic             i_tasks_done;
  logic             o_tm_rst;
  logic             o_start_tests;
  logic [31:0]      o_current_task_number;
  logic             o_busy;
  logic             o_all_done;
  logic             o_aborted;
  logic [31:0]      o_done_mask;
  logic [31:0]      o_timeout_mask;
  logic [CNT_W-1:0] o_last_cycles;

  modport master (
    input  i_run, i_abort, i_enabled_tasks, i_tasks_done,
    output o_tm_rst, o_start_tests, o_current_task_number, o_busy, o_all_done,
           o_aborted, o_done_mask, o_timeout_mask, o_last_cycles
  );

  modport slave (
    output i_run, i_abort, i_enabled_tasks, i_tasks_done,
    input  o_tm_rst, o_start_tests, o_current_task_number, o_busy, o_all_done,
           o_aborted, o_done_mask, o_timeout_mask, o_last_cycles
  );
endinterface

// File: rtl/task_scheduler.sv
// Walks the enabled-task mask, runs each task on task_manager and records
// per-task done/timeout status plus the latency of the last finished task.
module task_scheduler
  import task_scheduler_pkg::*;
#(
  parameter int unsigned NUMBER_OF_TASKS = 16,
  parameter int unsigned RST_CYCLES      = DEFAULT_RST_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W           = 32
) (
  input logic              i_clk,
  input logic              i_rst_n,
  task_scheduler_if.master bus
);

  localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RstW-1:0]       RstLast  = RstW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]      TmoLast  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]      TmoVal   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [TASK_IDX_W-1:0] NumTasks = TASK_IDX_W'(NUMBER_OF_TASKS);

  sched_state_e          state_q, state_d;
  logic [TASK_IDX_W-1:0] idx_q, idx_d, cand;
  logic [RstW-1:0]       rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      last_q, last_d;
  logic [31:0]           cur_q, cur_d;
  logic [31:0]           done_q, done_d;
  logic [31:0]           tmo_q, tmo_d;
  logic                  aborted_q, aborted_d;
  logic                  tm_rst_q, start_q, busy_q, all_done_q;
  logic [4:0]            task_bit;
  logic                  abort_req;

  assign cand      = idx_q + TASK_IDX_W'(1);
  // idx_q already holds the running task number k, so its mask bit is k-1.
  assign task_bit  = idx_q[4:0] - 5'd1;
  assign abort_req = bus.i_abort && (state_q != StIdle) && (state_q != StFinish);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rst_cnt_d = rst_cnt_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    cur_d     = cur_q;
    done_d    = done_q;
    tmo_d     = tmo_q;
    aborted_d = aborted_q;

    unique case (state_q)
      StIdle: begin
        if (bus.i_run) begin
          done_d    = '0;
          tmo_d     = '0;
          aborted_d = 1'b0;
          last_d    = '0;
          idx_d     = '0;
          state_d   = StScan;
        end
      end
      StScan: begin
        idx_d = cand;
        if (cand > NumTasks) begin
          state_d = StFinish;
        end else if (bus.i_enabled_tasks[idx_q[4:0]]) begin
          cur_d     = 32'(cand);
          rst_cnt_d = '0;
          state_d   = StRstTm;
        end
      end
      StRstTm: begin
        if (rst_cnt_q == RstLast) begin
          state_d = StStart;
        end else begin
          rst_cnt_d = rst_cnt_q + RstW'(1);
        end
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StWaitDone;
      end
      StWaitDone: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (bus.i_tasks_done) begin
          done_d[task_bit] = 1'b1;
          last_d           = cnt_q + CNT_W'(1);
          state_d          = StScan;
        end else if (cnt_q == TmoLast) begin
          tmo_d[task_bit] = 1'b1;
          last_d          = TmoVal;
          state_d         = StScan;
        end
      end
      StFinish: begin
        cur_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort beats a simultaneous done/timeout: results of the current task are discarded.
    if (abort_req) begin
      state_d   = StFinish;
      aborted_d = 1'b1;
      done_d    = done_q;
      tmo_d     = tmo_q;
      last_d    = last_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      rst_cnt_q  <= '0;
      cnt_q      <= '0;
      last_q     <= '0;
      cur_q      <= '0;
      done_q     <= '0;
      tmo_q      <= '0;
      aborted_q  <= 1'b0;
      tm_rst_q   <= 1'b1;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      all_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rst_cnt_q  <= rst_cnt_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      cur_q      <= cur_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
      aborted_q  <= aborted_d;
      // Control outputs are registered from the next state so they align with it.
      tm_rst_q   <= (state_d != StStart) && (state_d != StWaitDone);
      start_q    <= (state_d == StStart);
      busy_q     <= (state_d != StIdle);
      all_done_q <= (state_d == StFinish);
    end
  end

  assign bus.o_tm_rst              = tm_rst_q;
  assign bus.o_start_tests         = start_q;
  assign bus.o_current_task_number = cur_q;
  assign bus.o_busy                = busy_q;
  assign bus.o_all_done            = all_done_q;
  assign bus.o_aborted             = aborted_q;
  assign bus.o_done_mask           = done_q;
  assign bus.o_timeout_mask        = tmo_q;
  assign bus.o_last_cycles         = last_q;

endmodule

// File: tb/tb_task_scheduler.sv
// Directed bench for task_scheduler with a small behavioural task_manager.
module tb_task_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  task_scheduler_if #(.CNT_W(32)) bus ();

  task_scheduler #(
    .NUMBER_OF_TASKS(16),
    .RST_CYCLES     (4),
    .TIMEOUT_CYCLES (100),
    .CNT_W          (32)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Task manager model: raises sticky tasks_done done_delay cycles into WAIT_DONE.
  int done_delay = 0;
  int tcnt = 0;
  bit armed = 1'b0;
  int start_cnt = 0;
  int all_done_cnt = 0;
  logic [31:0] first_task = '0;
  logic [31:0] last_task = '0;

  always @(negedge clk) begin
    if (!rst_n || bus.o_tm_rst) begin
      bus.i_tasks_done = 1'b0;
      armed = 1'b0;
      tcnt = 0;
    end else if (bus.o_start_tests) begin
      armed = 1'b1;
      tcnt = 0;
      if (start_cnt == 0) first_task = bus.o_current_task_number;
      last_task = bus.o_current_task_number;
      start_cnt++;
    end else if (armed) begin
      tcnt++;
      if (done_delay != 0 && tcnt == done_delay) bus.i_tasks_done = 1'b1;
    end
    if (bus.o_all_done) all_done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_run(input logic [31:0] mask, input int delay);
    bus.i_enabled_tasks = mask;
    done_delay = delay;
    bus.i_run = 1'b1;
    step();
    bus.i_run = 1'b0;
  endtask

  task automatic wait_all_done(input string tag, output int cycles);
    cycles = 1;
    while (!bus.o_all_done && cycles < 3000) begin
      step();
      cycles++;
    end
    check({tag, "_all_done_reached"}, 32'(bus.o_all_done), 32'd1);
  endtask

  task automatic wait_starts(input string tag, input int target);
    int n = 0;
    while (start_cnt < target && n < 500) begin
      step();
      n++;
    end
    check({tag, "_start_reached"}, 32'(start_cnt >= target), 32'd1);
  endtask

  int cyc;
  int s0;
  int a0;

  initial begin
    bus.i_run = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_enabled_tasks = '0;
    bus.i_tasks_done = 1'b0;
    step();
    check("rst_tm_rst", 32'(bus.o_tm_rst), 32'd1);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_cur", bus.o_current_task_number, 32'd0);
    check("rst_all_done", 32'(bus.o_all_done), 32'd0);
    check("rst_done_mask", bus.o_done_mask, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // 1: two tasks each done 50 cycles after start.
    s0 = start_cnt;
    a0 = all_done_cnt;
    first_task = '0;
    start_cnt = 0;
    pulse_run(32'h0000_0201, 50);
    check("t1_busy", 32'(bus.o_busy), 32'd1);
    wait_all_done("t1", cyc);
    check("t1_done_mask", bus.o_done_mask, 32'h201);
    check("t1_timeout_mask", bus.o_timeout_mask, 32'h0);
    check("t1_first_task", first_task, 32'd1);
    check("t1_last_task", last_task, 32'd10);
    check("t1_starts", 32'(start_cnt), 32'd2);
    check("t1_all_done_pulses", 32'(all_done_cnt - a0), 32'd1);
    check("t1_last_cycles", bus.o_last_cycles, 32'd50);
    step();
    check("t1_idle_busy", 32'(bus.o_busy), 32'd0);
    check("t1_idle_tm_rst", 32'(bus.o_tm_rst), 32'd1);
    check("t1_idle_cur", bus.o_current_task_number, 32'd0);
    check("t1_all_done_single", 32'(bus.o_all_done), 32'd0);

    // 2: empty mask.
    s0 = start_cnt;
    pulse_run(32'h0, 0);
    wait_all_done("t2", cyc);
    check("t2_cycles", 32'(cyc), 32'd18);
    check("t2_starts", 32'(start_cnt - s0), 32'd0);
    check("t2_done_mask", bus.o_done_mask, 32'h0);
    check("t2_timeout_mask", bus.o_timeout_mask, 32'h0);
    step();

    // 3: task 3 never completes.
    pulse_run(32'h4, 0);
    wait_all_done("t3", cyc);
    check("t3_timeout_mask", bus.o_timeout_mask, 32'h4);
    check("t3_done_mask", bus.o_done_mask, 32'h0);
    check("t3_last_cycles", bus.o_last_cycles, 32'd100);
    step();

    // 4: done on the final timeout cycle.
    pulse_run(32'h1, 100);
    wait_all_done("t4", cyc);
    check("t4_done_mask", bus.o_done_mask, 32'h1);
    check("t4_timeout_mask", bus.o_timeout_mask, 32'h0);
    check("t4_last_cycles", bus.o_last_cycles, 32'd100);
    step();

    // 5: abort while task 1 waits.
    s0 = start_cnt;
    pulse_run(32'h3, 0);
    wait_starts("t5", s0 + 1);
    repeat (10) step();
    bus.i_abort = 1'b1;
    step();
    bus.i_abort = 1'b0;
    check("t5_all_done", 32'(bus.o_all_done), 32'd1);
    check("t5_aborted", 32'(bus.o_aborted), 32'd1);
    check("t5_done_mask", bus.o_done_mask, 32'h0);
    check("t5_timeout_mask", bus.o_timeout_mask, 32'h0);
    step();
    check("t5_idle_tm_rst", 32'(bus.o_tm_rst), 32'd1);
    check("t5_idle_busy", 32'(bus.o_busy), 32'd0);
    repeat (5) step();
    check("t5_starts", 32'(start_cnt - s0), 32'd1);

    // 6a: second i_run mid-run is ignored.
    s0 = start_cnt;
    a0 = all_done_cnt;
    pulse_run(32'h3, 50);
    repeat (20) step();
    bus.i_run = 1'b1;
    step();
    bus.i_run = 1'b0;
    wait_all_done("t6", cyc);
    check("t6_done_mask", bus.o_done_mask, 32'h3);
    check("t6_starts", 32'(start_cnt - s0), 32'd2);
    check("t6_aborted_cleared", 32'(bus.o_aborted), 32'd0);
    step();
    repeat (5) step();
    check("t6_all_done_pulses", 32'(all_done_cnt - a0), 32'd1);
    check("t6_still_idle", 32'(bus.o_busy), 32'd0);

    // 6b: async reset during task 2, then a fresh run.
    s0 = start_cnt;
    pulse_run(32'h3, 50);
    wait_starts("t6r", s0 + 2);
    repeat (5) step();
    a0 = all_done_cnt;
    rst_n = 1'b0;
    #1;
    check("t6r_tm_rst", 32'(bus.o_tm_rst), 32'd1);
    check("t6r_busy", 32'(bus.o_busy), 32'd0);
    check("t6r_cur", bus.o_current_task_number, 32'd0);
    check("t6r_done_mask", bus.o_done_mask, 32'h0);
    check("t6r_last_cycles", bus.o_last_cycles, 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("t6r_no_all_done", 32'(all_done_cnt - a0), 32'd0);
    pulse_run(32'h1, 7);
    wait_all_done("t6f", cyc);
    check("t6f_done_mask", bus.o_done_mask, 32'h1);
    check("t6f_last_cycles", bus.o_last_cycles, 32'd7);
    check("t6f_timeout_mask", bus.o_timeout_mask, 32'h0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
